// File: rtl/piso_n_unloader_pkg.sv
// Purpose: types and helpers shared by the parallel-in/serial-out unloader.
// Contents:
//   piso_state_t - FSM state encoding (IDLE, SEND)
//   cnt_width()  - word counter width, never less than 1 bit
package pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } piso_state_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_n_unloader_if.sv
// Purpose: load and output stream handshake bundle for piso_n_unloader.
// Signals:
//   load_valid/load_ready/load_data - parallel vector load handshake
//   out_valid/out_ready/out_data    - serial word stream
//   out_last                        - current word is index 0 of the vector
// Modports:
//   slave  - the unloader side
//   master - the producer/consumer side that drives load_* and out_ready
interface piso_n_unloader_if #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 5
);

  logic                          load_valid;
  logic                          load_ready;
  logic [WIDTH-1:0][HEIGHT-1:0]  load_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [HEIGHT-1:0]             out_data;
  logic                          out_last;

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, out_data, out_last
  );

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/piso_n_unloader_stage.sv
// Purpose: one word register of the unloader shift chain.
// Ports:
//   clk_i        - clock
//   reset_i      - synchronous active-high reset, clears the word
//   load_i       - capture load_data_i (highest priority)
//   shift_i      - capture shift_data_i from the neighbour below
//   load_data_i  - parallel load value
//   shift_data_i - value shifted in from the lower index
//   data_o       - registered word
module piso_stage #(
  parameter int HEIGHT = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [HEIGHT-1:0] load_data_i,
  input  logic [HEIGHT-1:0] shift_data_i,
  output logic [HEIGHT-1:0] data_o
);

  logic [HEIGHT-1:0] data_q;
  logic [HEIGHT-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = shift_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/piso_n_unloader.sv
// Purpose: accepts a packed [WIDTH-1:0][HEIGHT-1:0] vector in one handshake
//   and emits it one word per cycle, index WIDTH-1 first, index 0 last.
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset
//   bus     - piso_n_unloader_if.slave (load and output streams)
//   busy_o  - high while a vector is being emitted
//
// state | meaning
// IDLE  | no vector held; ready to load; out_valid low
// SEND  | presenting word_q[WIDTH-1]; shifts up on each handshake
module piso_n_unloader
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  piso_n_unloader_if.slave   bus,
  output logic               busy_o
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  piso_state_t                    state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [WIDTH-1:0][HEIGHT-1:0]   word_q;

  logic is_send;
  logic is_last;
  logic out_hs;
  logic accept;
  logic shift_en;
  logic clear_en;
  logic stage_load;

  assign is_send  = (state_q == SEND);
  assign is_last  = is_send && (cnt_q == CNT_LAST);
  assign out_hs   = is_send && bus.out_ready;

  // Combinational from out_ready so a new vector can follow the last word
  // without a bubble.
  assign bus.load_ready = (state_q == IDLE) || (is_send && bus.out_ready && is_last);
  assign accept         = bus.load_valid && bus.load_ready;

  assign shift_en   = out_hs && !is_last;
  // Final word leaves with nothing behind it: wipe the chain so IDLE holds zeros.
  assign clear_en   = out_hs && is_last && !bus.load_valid;
  assign stage_load = accept || clear_en;

  assign bus.out_valid = is_send;
  assign bus.out_last  = is_last;
  assign bus.out_data  = is_send ? word_q[WIDTH-1] : '0;
  assign busy_o        = is_send;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic [HEIGHT-1:0] shift_in;
    if (i == 0) begin : g_bottom
      assign shift_in = '0;
    end else begin : g_upper
      assign shift_in = word_q[i-1];
    end

    piso_stage #(.HEIGHT(HEIGHT)) u_stage (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (stage_load),
      .shift_i      (shift_en),
      .load_data_i  (accept ? bus.load_data[i] : '0),
      .shift_data_i (shift_in),
      .data_o       (word_q[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (!is_last) begin
            cnt_d = cnt_q + CW'(1);
          end else if (bus.load_valid) begin
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_n_unloader.sv
// Directed table of per-cycle inputs and expected outputs for a 4x5 unloader,
// followed by randomised round trips through a model serial-in/parallel-out
// chain and a short WIDTH=1 sequence.
module tb_piso_n_unloader;

  logic clk;
  logic reset;
  logic busy;
  logic busy1;

  int checks = 0;
  int errors = 0;

  piso_n_unloader_if #(.WIDTH(4), .HEIGHT(5)) bus ();
  piso_n_unloader_if #(.WIDTH(1), .HEIGHT(5)) bus1 ();

  piso_n_unloader #(.WIDTH(4), .HEIGHT(5)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus),
    .busy_o  (busy)
  );

  piso_n_unloader #(.WIDTH(1), .HEIGHT(5)) dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus1),
    .busy_o  (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        lv;
    logic [19:0] ld;
    logic        ordy;
    logic        chk;
    logic        ov;
    logic [4:0]  od;
    logic        ol;
    logic        lr;
    logic        bz;
  } vec_t;

  vec_t tbl[$];

  localparam logic [19:0] V1 = {5'h04, 5'h03, 5'h02, 5'h01};
  localparam logic [19:0] V2 = {5'h1F, 5'h1E, 5'h1D, 5'h1C};
  localparam logic [19:0] V3 = {5'h0A, 5'h0B, 5'h0C, 5'h0D};
  localparam logic [19:0] V4 = {5'h11, 5'h12, 5'h13, 5'h14};

  task automatic add(input logic r, input logic lv, input logic [19:0] ld,
                     input logic ordy, input logic chk, input logic ov,
                     input logic [4:0] od, input logic ol, input logic lr,
                     input logic bz);
    vec_t v;
    v.rst = r; v.lv = lv; v.ld = ld; v.ordy = ordy; v.chk = chk;
    v.ov = ov; v.od = od; v.ol = ol; v.lr = lr; v.bz = bz;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [3:0][4:0] vec;
  logic [3:0][4:0] chain;
  int hs;
  int cyc;

  initial begin
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.out_ready  = 1'b0;
    bus1.load_valid = 1'b0;
    bus1.load_data  = '0;
    bus1.out_ready  = 1'b0;

    //   rst lv  ld  ordy chk ov  od     ol  lr  bz
    add(1, 0, '0, 0, 0, 0, 5'h00, 0, 1, 0);   // reset, not yet sampled
    add(1, 0, '0, 0, 1, 0, 5'h00, 0, 1, 0);
    add(0, 0, '0, 0, 1, 0, 5'h00, 0, 1, 0);
    // plain 4-word vector, downstream always ready
    add(0, 1, V1, 1, 1, 0, 5'h00, 0, 1, 0);
    add(0, 0, '0, 1, 1, 1, 5'h04, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h03, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h02, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h01, 1, 1, 1);
    add(0, 0, '0, 1, 1, 0, 5'h00, 0, 1, 0);
    // back-pressure 1,0,0,1,1,0,1
    add(0, 1, V1, 0, 1, 0, 5'h00, 0, 1, 0);
    add(0, 0, '0, 1, 1, 1, 5'h04, 0, 0, 1);
    add(0, 0, '0, 0, 1, 1, 5'h03, 0, 0, 1);
    add(0, 0, '0, 0, 1, 1, 5'h03, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h03, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h02, 0, 0, 1);
    add(0, 0, '0, 0, 1, 1, 5'h01, 1, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h01, 1, 1, 1);
    add(0, 0, '0, 1, 1, 0, 5'h00, 0, 1, 0);
    // back-to-back: second vector held on load_valid, ignored until last word
    add(0, 1, V1, 1, 1, 0, 5'h00, 0, 1, 0);
    add(0, 1, V2, 1, 1, 1, 5'h04, 0, 0, 1);
    add(0, 1, V2, 1, 1, 1, 5'h03, 0, 0, 1);
    add(0, 1, V2, 1, 1, 1, 5'h02, 0, 0, 1);
    add(0, 1, V2, 1, 1, 1, 5'h01, 1, 1, 1);
    add(0, 0, '0, 1, 1, 1, 5'h1F, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h1E, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h1D, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h1C, 1, 1, 1);
    add(0, 0, '0, 1, 1, 0, 5'h00, 0, 1, 0);
    // reset after the second handshake, then a fresh load
    add(0, 1, V3, 1, 1, 0, 5'h00, 0, 1, 0);
    add(0, 0, '0, 1, 1, 1, 5'h0A, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h0B, 0, 0, 1);
    add(1, 0, '0, 1, 1, 1, 5'h0C, 0, 0, 1);
    add(0, 0, '0, 0, 1, 0, 5'h00, 0, 1, 0);
    add(0, 1, V4, 0, 1, 0, 5'h00, 0, 1, 0);
    add(0, 0, '0, 0, 1, 1, 5'h11, 0, 0, 1);
    add(0, 0, '0, 0, 1, 1, 5'h11, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h11, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h12, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h13, 0, 0, 1);
    add(0, 0, '0, 1, 1, 1, 5'h14, 1, 1, 1);
    add(0, 0, '0, 0, 1, 0, 5'h00, 0, 1, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      reset          = tbl[k].rst;
      bus.load_valid = tbl[k].lv;
      bus.load_data  = tbl[k].ld;
      bus.out_ready  = tbl[k].ordy;
      #1;
      if (tbl[k].chk) begin
        check($sformatf("row%0d_out_valid", k),  32'(bus.out_valid),  32'(tbl[k].ov));
        check($sformatf("row%0d_out_data", k),   32'(bus.out_data),   32'(tbl[k].od));
        check($sformatf("row%0d_out_last", k),   32'(bus.out_last),   32'(tbl[k].ol));
        check($sformatf("row%0d_load_ready", k), 32'(bus.load_ready), 32'(tbl[k].lr));
        check($sformatf("row%0d_busy", k),       32'(busy),           32'(tbl[k].bz));
      end
    end

    // random vectors rebuilt through a 4-deep serial-in/parallel-out chain
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < 4; w++) vec[w] = 5'($urandom_range(0, 31));
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_data  = vec;
      bus.out_ready  = 1'b0;
      #1;
      check($sformatf("rnd%0d_load_ready", v), 32'(bus.load_ready), 32'd1);
      @(negedge clk);
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      hs    = 0;
      cyc   = 0;
      chain = '0;
      while (hs < 4 && cyc < 60) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.out_valid && bus.out_ready) begin
          check($sformatf("rnd%0d_last_hs%0d", v, hs), 32'(bus.out_last), 32'(hs == 3));
          chain = {chain[2:0], bus.out_data};
          hs++;
        end
        @(negedge clk);
        cyc++;
      end
      check($sformatf("rnd%0d_in_time", v), 32'(cyc < 60), 32'd1);
      bus.out_ready = 1'b0;
      #1;
      check($sformatf("rnd%0d_idle_after", v), 32'(bus.out_valid), 32'd0);
      check($sformatf("rnd%0d_chain", v), 32'(chain), 32'(vec));
    end

    // single-word vectors: every word is last
    @(negedge clk);
    bus1.load_valid = 1'b1;
    bus1.load_data  = 5'h15;
    bus1.out_ready  = 1'b0;
    #1;
    check("w1_load_ready_idle", 32'(bus1.load_ready), 32'd1);
    check("w1_out_valid_idle", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    bus1.load_valid = 1'b0;
    bus1.load_data  = '0;
    #1;
    check("w1_out_valid", 32'(bus1.out_valid), 32'd1);
    check("w1_out_data", 32'(bus1.out_data), 32'h15);
    check("w1_out_last", 32'(bus1.out_last), 32'd1);
    check("w1_load_ready_stalled", 32'(bus1.load_ready), 32'd0);
    @(negedge clk);
    bus1.out_ready = 1'b1;
    #1;
    check("w1_out_data_held", 32'(bus1.out_data), 32'h15);
    check("w1_load_ready_last", 32'(bus1.load_ready), 32'd1);
    @(negedge clk);
    bus1.out_ready = 1'b0;
    #1;
    check("w1_idle_after", 32'(bus1.out_valid), 32'd0);
    check("w1_busy_after", 32'(busy1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
